// File: rtl/msu_sd_pkg.sv
// Shared types and constants for the MSU SD sector arbiter.
package msu_sd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int unsigned REQ_AUDIO        = 0;
    localparam int unsigned REQ_DATA         = 1;
    localparam int unsigned WORDS_PER_SECTOR = 256;
    localparam int unsigned TIMER_W          = 24;
    localparam int unsigned WCNT_W           = 9;
    localparam int unsigned LBA_W            = 32;

    // One-hot grant vector for a requester index.
    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/msu_sd_watchdog.sv
// Request-phase watchdog: counts enabled cycles from zero, flags the last allowed one.
module msu_sd_watchdog
    import msu_sd_pkg::*;
#(
    parameter logic [TIMER_W-1:0] TIMEOUT = 24'd1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    logic [TIMER_W-1:0] count;

    // Cycle counter, held at zero while cleared and saturating at full scale.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (enable && count != '1) begin
            count <= count + TIMER_W'(1);
        end
    end

    assign expire = enable && (count == TIMEOUT - TIMER_W'(1));

endmodule

// File: rtl/msu_sd_arbiter.sv
// Round-robin arbiter sharing one HPS SD sector channel between audio and data requesters.
module msu_sd_arbiter
    import msu_sd_pkg::*;
#(
    parameter logic [TIMER_W-1:0] TIMEOUT = 24'd1000000,
    parameter logic [WCNT_W-1:0]  WORDS   = WCNT_W'(WORDS_PER_SECTOR)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_rd,
    input  logic [LBA_W-1:0] req_lba0,
    input  logic [LBA_W-1:0] req_lba1,
    input  logic [1:0]       req_cancel,
    output logic [LBA_W-1:0] sd_lba,
    output logic             sd_rd,
    input  logic             sd_ack,
    input  logic             sd_buff_wr,
    output logic [1:0]       grant,
    output logic [1:0]       req_ack,
    output logic [1:0]       req_wr,
    output logic [1:0]       req_err
);

    state_t              state;
    logic                owner;
    logic                last;
    logic                suppress;
    logic [WCNT_W-1:0]   word_cnt;
    logic                expire;
    logic                busy;
    logic                cancel_hit;
    logic                mask;
    logic                pass;
    logic                pick;

    assign busy       = (state == ST_REQ) || (state == ST_XFER);
    assign cancel_hit = busy && req_cancel[owner];
    assign mask       = suppress || cancel_hit;
    assign pass       = reset_n && busy && !mask;

    // Audio wins unless data is also asking and audio was served last.
    assign pick = (req_rd[REQ_AUDIO] && (!req_rd[REQ_DATA] || last)) ? 1'b0 : 1'b1;

    // Owner-qualified HPS strobes; silenced once the owner has cancelled.
    assign req_ack = pass ? (grant & {2{sd_ack}})     : 2'b00;
    assign req_wr  = pass ? (grant & {2{sd_buff_wr}}) : 2'b00;

    msu_sd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (state == ST_REQ),
        .clear   (state != ST_REQ),
        .expire  (expire)
    );

    // Arbitration and transfer sequencing with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            sd_rd    <= 1'b0;
            sd_lba   <= '0;
            grant    <= 2'b00;
            req_err  <= 2'b00;
            suppress <= 1'b0;
            word_cnt <= '0;
            last     <= 1'b1;
            owner    <= 1'b0;
        end else begin
            req_err <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (|req_rd) begin
                        owner  <= pick;
                        grant  <= onehot(pick);
                        sd_lba <= pick ? req_lba1 : req_lba0;
                        sd_rd  <= 1'b1;
                        state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (cancel_hit) suppress <= 1'b1;
                    if (sd_ack) begin
                        sd_rd <= 1'b0;
                        state <= ST_XFER;
                    end else if (expire) begin
                        sd_rd   <= 1'b0;
                        req_err <= mask ? 2'b00 : grant;
                        state   <= ST_GAP;
                    end
                end
                ST_XFER: begin
                    if (cancel_hit) suppress <= 1'b1;
                    if (sd_buff_wr && word_cnt != '1) word_cnt <= word_cnt + WCNT_W'(1);
                    if (!sd_ack) begin
                        if (word_cnt != WORDS && !mask) req_err <= grant;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    grant    <= 2'b00;
                    last     <= owner;
                    word_cnt <= '0;
                    suppress <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msu_sd_arbiter.sv
// Self-checking bench for msu_sd_arbiter with a transaction-level round-robin model.
module tb_msu_sd_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_rd, req_cancel;
    logic [31:0] req_lba0, req_lba1, sd_lba;
    logic        sd_rd, sd_ack, sd_buff_wr;
    logic [1:0]  grant, req_ack, req_wr, req_err;

    int errors = 0;
    int checks = 0;
    int tot_wr[2]  = '{0, 0};
    int tot_ack[2] = '{0, 0};
    int tot_err[2] = '{0, 0};
    int tot_rd   = 0;
    int tot_idle = 0;
    int d_wr[2], d_ack[2], d_err[2];
    int d_rd;
    int m_last;

    always #5 clk = ~clk;

    msu_sd_arbiter #(.TIMEOUT(24'd16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_rd     (req_rd),
        .req_lba0   (req_lba0),
        .req_lba1   (req_lba1),
        .req_cancel (req_cancel),
        .sd_lba     (sd_lba),
        .sd_rd      (sd_rd),
        .sd_ack     (sd_ack),
        .sd_buff_wr (sd_buff_wr),
        .grant      (grant),
        .req_ack    (req_ack),
        .req_wr     (req_wr),
        .req_err    (req_err)
    );

    // Running totals of observed pulses, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            tot_wr[i]  += int'(req_wr[i]);
            tot_ack[i] += int'(req_ack[i]);
            tot_err[i] += int'(req_err[i]);
        end
        tot_rd   += int'(sd_rd);
        tot_idle += int'(grant == 2'b00);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: contention goes to the requester not served last.
    function automatic int rr_pick(input logic [1:0] rq, input int last);
        if (rq == 2'b11) return 1 - last;
        return rq[0] ? 0 : 1;
    endfunction

    function automatic logic [1:0] oh(input int idx);
        return (idx == 1) ? 2'b10 : 2'b01;
    endfunction

    // Plays the HPS side of one sector transaction and records pulse deltas.
    task automatic do_xfer(input int ack_delay, input int nwords, input int cancel_at,
                           input bit cancel_owner, input bit to_mode, input bit gaps,
                           input bit drop_req, output logic [1:0] g, output logic [31:0] lba);
        int n;
        int s_wr[2], s_ack[2], s_err[2];
        int s_rd;
        n = 0;
        while (sd_rd !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (sd_rd !== 1'b1) begin
            errors++;
            $display("FAIL xfer_start: sd_rd=%b required 1 within 20 cycles", sd_rd);
        end
        g = grant;
        lba = sd_lba;
        s_wr = tot_wr; s_ack = tot_ack; s_err = tot_err; s_rd = tot_rd;
        if (drop_req) req_rd = 2'b00;
        if (!to_mode) begin
            repeat (ack_delay) step();
            sd_ack = 1'b1;
            step();
            for (int w = 0; w < nwords; w++) begin
                if (w == cancel_at) begin
                    req_cancel = cancel_owner ? g : ~g;
                    step();
                    req_cancel = 2'b00;
                end
                if (gaps && $urandom_range(0, 3) == 0) step();
                sd_buff_wr = 1'b1;
                step();
                sd_buff_wr = 1'b0;
            end
            step();
            sd_ack = 1'b0;
        end
        n = 0;
        while (grant !== 2'b00 && n < 40) begin step(); n++; end
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL xfer_end: grant=%b required 00 within 40 cycles", grant);
        end
        for (int i = 0; i < 2; i++) begin
            d_wr[i]  = tot_wr[i]  - s_wr[i];
            d_ack[i] = tot_ack[i] - s_ack[i];
            d_err[i] = tot_err[i] - s_err[i];
        end
        d_rd = tot_rd - s_rd;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_rd = 2'b00; req_cancel = 2'b00;
        req_lba0 = 32'h0000_0010; req_lba1 = 32'h2000_0020;
        sd_ack = 1'b1; sd_buff_wr = 1'b1;
        repeat (3) step();
        checks++; if (sd_rd !== 1'b0)    begin errors++; $display("FAIL reset_sd_rd: got %b required 0", sd_rd); end
        checks++; if (grant !== 2'b00)   begin errors++; $display("FAIL reset_grant: got %b required 00", grant); end
        checks++; if (sd_lba !== 32'h0)  begin errors++; $display("FAIL reset_lba: got %h required 0", sd_lba); end
        checks++; if (req_err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b required 00", req_err); end
        checks++; if (req_ack !== 2'b00 || req_wr !== 2'b00) begin
            errors++; $display("FAIL reset_strobes: ack=%b wr=%b required 00/00", req_ack, req_wr);
        end
        sd_ack = 1'b0; sd_buff_wr = 1'b0; reset_n = 1'b1;
        step();
        m_last = 1;
    endtask

    task automatic test_contention();
        logic [1:0] g; logic [31:0] lba; int exp; int s_idle;
        s_idle = 0;
        req_rd = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp = rr_pick(2'b11, m_last);
            do_xfer(2, 256, -1, 1'b0, 1'b0, 1'b0, 1'b0, g, lba);
            if (t == 0) s_idle = tot_idle;
            checks++; if (g !== oh(exp)) begin errors++; $display("FAIL contention_grant[%0d]: got %b required %b", t, g, oh(exp)); end
            checks++; if (lba !== ((exp == 1) ? req_lba1 : req_lba0)) begin errors++; $display("FAIL contention_lba[%0d]: got %h", t, lba); end
            checks++; if (d_err[0] != 0 || d_err[1] != 0) begin errors++; $display("FAIL contention_err[%0d]: got %0d/%0d required 0/0", t, d_err[0], d_err[1]); end
            m_last = exp;
        end
        req_rd = 2'b00;
        checks++; if (tot_idle - s_idle != 3) begin errors++; $display("FAIL contention_gap: idle cycles %0d required 3", tot_idle - s_idle); end
    endtask

    task automatic test_single();
        logic [1:0] g; logic [31:0] lba;
        req_lba0 = 32'h0000_0010;
        req_rd = 2'b01;
        do_xfer(3, 256, 60, 1'b0, 1'b0, 1'b0, 1'b1, g, lba);
        checks++; if (g !== 2'b01)        begin errors++; $display("FAIL single_grant: got %b required 01", g); end
        checks++; if (lba !== 32'h10)     begin errors++; $display("FAIL single_lba: got %h required 10", lba); end
        checks++; if (d_wr[0] != 256 || d_wr[1] != 0) begin errors++; $display("FAIL single_wr: got %0d/%0d required 256/0", d_wr[0], d_wr[1]); end
        checks++; if (d_err[0] != 0 || d_err[1] != 0) begin errors++; $display("FAIL single_err: got %0d/%0d required 0/0", d_err[0], d_err[1]); end
        checks++; if (d_rd != 4)          begin errors++; $display("FAIL single_rd_len: got %0d required 4", d_rd); end
        checks++; if (d_ack[0] != 259 || d_ack[1] != 0) begin errors++; $display("FAIL single_ack: got %0d/%0d required 259/0", d_ack[0], d_ack[1]); end
        m_last = 0;
    endtask

    task automatic test_ignore();
        logic [1:0] g; logic [31:0] lba; int s_wr0, s_wr1, s_ack0, s_ack1;
        req_rd = 2'b00;
        s_wr0 = tot_wr[0]; s_wr1 = tot_wr[1]; s_ack0 = tot_ack[0]; s_ack1 = tot_ack[1];
        sd_ack = 1'b1; sd_buff_wr = 1'b1;
        repeat (4) step();
        checks++; if (grant !== 2'b00 || sd_rd !== 1'b0) begin errors++; $display("FAIL ignore_idle: grant=%b sd_rd=%b required 00/0", grant, sd_rd); end
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
        step();
        checks++; if (tot_wr[0] != s_wr0 || tot_wr[1] != s_wr1 || tot_ack[0] != s_ack0 || tot_ack[1] != s_ack1) begin
            errors++; $display("FAIL ignore_strobes: req_* pulses seen while idle");
        end
        req_rd = 2'b10;
        do_xfer(1, 256, -1, 1'b0, 1'b0, 1'b1, 1'b1, g, lba);
        checks++; if (g !== 2'b10 || d_wr[1] != 256 || d_err[1] != 0) begin
            errors++; $display("FAIL ignore_next: grant=%b wr=%0d err=%0d required 10/256/0", g, d_wr[1], d_err[1]);
        end
        m_last = 1;
    endtask

    task automatic test_timeout();
        logic [1:0] g; logic [31:0] lba;
        req_rd = 2'b01;
        do_xfer(0, 0, -1, 1'b0, 1'b1, 1'b0, 1'b1, g, lba);
        checks++; if (g !== 2'b01) begin errors++; $display("FAIL timeout_grant: got %b required 01", g); end
        checks++; if (d_rd != 16)  begin errors++; $display("FAIL timeout_rd_len: got %0d required 16", d_rd); end
        checks++; if (d_err[0] != 1 || d_err[1] != 0) begin errors++; $display("FAIL timeout_err: got %0d/%0d required 1/0", d_err[0], d_err[1]); end
        step();
        checks++; if (sd_rd !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL timeout_idle: sd_rd=%b grant=%b required 0/00", sd_rd, grant); end
        m_last = 0;
    endtask

    task automatic test_short();
        logic [1:0] g; logic [31:0] lba;
        req_rd = 2'b10;
        do_xfer(2, 200, -1, 1'b0, 1'b0, 1'b0, 1'b1, g, lba);
        checks++; if (d_wr[1] != 200) begin errors++; $display("FAIL short_wr: got %0d required 200", d_wr[1]); end
        checks++; if (d_err[1] != 1 || d_err[0] != 0) begin errors++; $display("FAIL short_err: got %0d/%0d required 0/1", d_err[0], d_err[1]); end
        m_last = 1;
    endtask

    task automatic test_cancel();
        logic [1:0] g; logic [31:0] lba;
        req_rd = 2'b10;
        do_xfer(2, 256, 100, 1'b1, 1'b0, 1'b0, 1'b1, g, lba);
        checks++; if (g !== 2'b10) begin errors++; $display("FAIL cancel_grant: got %b required 10", g); end
        checks++; if (d_wr[1] != 100) begin errors++; $display("FAIL cancel_wr: got %0d required 100", d_wr[1]); end
        checks++; if (d_ack[1] != 101) begin errors++; $display("FAIL cancel_ack: got %0d required 101", d_ack[1]); end
        checks++; if (d_err[0] != 0 || d_err[1] != 0) begin errors++; $display("FAIL cancel_err: got %0d/%0d required 0/0", d_err[0], d_err[1]); end
        m_last = 1;
    endtask

    task automatic test_random();
        logic [1:0] g, rq; logic [31:0] lba;
        int exp, dly, nw, cat, ewr, eerr;
        bit cown;
        for (int it = 0; it < 8; it++) begin
            rq = 2'($urandom_range(1, 3));
            req_lba0 = $urandom; req_lba1 = $urandom;
            exp  = rr_pick(rq, m_last);
            dly  = int'($urandom_range(0, 8));
            nw   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(180, 330)) : 256;
            cat  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nw - 1)) : -1;
            cown = 1'($urandom_range(0, 1));
            ewr  = (cat >= 0 && cown) ? cat : nw;
            eerr = (!(cat >= 0 && cown) && nw != 256) ? 1 : 0;
            req_rd = rq;
            do_xfer(dly, nw, cat, cown, 1'b0, 1'b1, 1'b1, g, lba);
            checks++; if (g !== oh(exp)) begin errors++; $display("FAIL rand_grant[%0d]: got %b required %b", it, g, oh(exp)); end
            checks++; if (lba !== ((exp == 1) ? req_lba1 : req_lba0)) begin errors++; $display("FAIL rand_lba[%0d]: got %h", it, lba); end
            checks++; if (d_wr[exp] != ewr || d_wr[1 - exp] != 0) begin errors++; $display("FAIL rand_wr[%0d]: got %0d/%0d required %0d/0", it, d_wr[exp], d_wr[1 - exp], ewr); end
            checks++; if (d_err[exp] != eerr || d_err[1 - exp] != 0) begin errors++; $display("FAIL rand_err[%0d]: got %0d required %0d", it, d_err[exp], eerr); end
            checks++; if (d_rd != dly + 1) begin errors++; $display("FAIL rand_rd_len[%0d]: got %0d required %0d", it, d_rd, dly + 1); end
            m_last = exp;
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] g; logic [31:0] lba; int n;
        req_rd = 2'b01;
        do_xfer(1, 256, -1, 1'b0, 1'b0, 1'b0, 1'b1, g, lba);
        m_last = 0;
        req_rd = 2'b01;
        n = 0;
        while (sd_rd !== 1'b1 && n < 20) begin step(); n++; end
        checks++; if (sd_rd !== 1'b1) begin errors++; $display("FAIL midrst_start: sd_rd=%b required 1", sd_rd); end
        req_rd = 2'b00;
        sd_ack = 1'b1;
        step();
        repeat (10) begin sd_buff_wr = 1'b1; step(); sd_buff_wr = 1'b0; end
        sd_buff_wr = 1'b1;
        reset_n = 1'b0;
        #1;
        checks++; if (req_wr !== 2'b00 || req_ack !== 2'b00) begin errors++; $display("FAIL midrst_strobes: ack=%b wr=%b required 00/00", req_ack, req_wr); end
        step();
        checks++; if (sd_rd !== 1'b0 || grant !== 2'b00 || req_err !== 2'b00) begin
            errors++; $display("FAIL midrst_state: sd_rd=%b grant=%b err=%b required 0/00/00", sd_rd, grant, req_err);
        end
        reset_n = 1'b1; sd_ack = 1'b0; sd_buff_wr = 1'b0;
        m_last = 1;
        step();
        req_rd = 2'b11;
        do_xfer(1, 256, -1, 1'b0, 1'b0, 1'b0, 1'b1, g, lba);
        checks++; if (g !== oh(rr_pick(2'b11, m_last))) begin errors++; $display("FAIL midrst_rr: got %b required %b", g, oh(rr_pick(2'b11, m_last))); end
        m_last = rr_pick(2'b11, m_last);
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_ignore();
        test_timeout();
        test_short();
        test_cancel();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
